uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Message-level round-robin arbiter that shares one `uart_tx` transmitter between `N` byte-stream requesters. A requester that wins keeps the transmitter until the byte flagged `last` has been accepted by the UART. If a requester stalls mid-message, a watchdog releases the grant. The block sits between client logic (debug console, status reporter, loopback) and the `tx_data` / `tx_data_valid` / `tx_data_ack` port of `uart_tx`.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 50000: max idle cycles inside a message before forced release; 0 disables the watchdog. 16-bit.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_data`  in  8*N  byte from requester i at `[8i+7:8i]`.
- `req_valid`  in  N  requester i has a byte; held until its `req_ack`.
- `req_last`  in  N  qualifies `req_data`: byte is the final byte of the message.
- `req_ack`  out  N  one-cycle pulse: byte of requester i captured.
- `grant`  out  N  one-hot owner of the transmitter; all-zero when idle.
- `tx_data`  out  8  to `uart_tx`.
- `tx_data_valid`  out  1  to `uart_tx`.
- `tx_data_ack`  in  1  from `uart_tx`; one-cycle pulse, arrives the cycle after the UART accepts.
- `timeout`  out  1  one-cycle pulse on watchdog release.

## Operation
- States:
  - IDLE: no owner.
  - SEND: `tx_data_valid`=1, waiting for `tx_data_ack`.
  - NEXT: owner holds the grant and is waiting for its next byte.
- Round-robin pointer `ptr` (width clog2 N).
  - Winner = first i with `req_valid[i]`, searching from `ptr` upward with wrap.
  - `ptr` <= winner+1 mod N on message completion or timeout, so the pointer moves only at message boundaries.
- IDLE, any `req_valid`:
  - Capture winner's byte into `tx_data` and its `req_last` into `last_q`.
  - Set `grant`=onehot(winner), `tx_data_valid`=1, `req_ack[winner]`=1; go to SEND.
- SEND:
  - All `req_valid` ignored.
  - On `tx_data_ack`: `tx_data_valid`<=0.
  - If `last_q`: `grant`<=0, advance `ptr`, go to IDLE. Otherwise go to NEXT and clear the watchdog count.
- NEXT:
  - Only the owner's `req_valid` is considered; other requesters wait.
  - Owner valid: capture its byte and last, pulse `req_ack`, `tx_data_valid`=1, go to SEND.
  - Else count up. If the count reaches TIMEOUT-1 (with TIMEOUT≠0): pulse `timeout`, `grant`<=0, advance `ptr`, go to IDLE.
- `tx_data_ack` outside SEND is ignored.
- `tx_data` holds its last value when `tx_data_valid`=0.
- Single-byte message (`last`=1 on the first byte) is legal.
- Reset (asynchronous, any state):
  - State IDLE, `ptr`=0, watchdog count 0.
  - All outputs 0: `grant`, `req_ack`, `tx_data`, `tx_data_valid`, `timeout`.
  - A byte already accepted by the UART is not recalled.

## Timing
- All outputs registered.
- Latency:
  - IDLE/NEXT with valid at edge k → `tx_data_valid`, `req_ack`, and `grant` (first byte) high after edge k.
  - Capture-to-deassert: `tx_data_valid` stays high through the `tx_data_ack` cycle and falls on the following edge. The UART is not ready in the ack cycle, so there is no double acceptance.
  - After ack of a non-last byte, NEXT is entered. Earliest next capture is one cycle later.
  - After ack of a last byte, IDLE is entered. The next arbitration is one cycle later.
- Requester must present new data (or drop valid) on the cycle after `req_ack`. The arbiter never re-samples in SEND.
- Watchdog: released exactly TIMEOUT cycles after entering NEXT without owner valid. `timeout` and `grant`=0 appear on the same edge.
- Throughput is bounded by the UART: one byte per frame period.

## Test plan
- Single requester, N=4:
  - Stimulus: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), UART stub acks 2 cycles after valid.
  - Required: `grant`=0001 throughout; 3 `req_ack` pulses; `tx_data` sequence matches; `grant`=0 one cycle after the third ack; `ptr`=1.
- Fairness:
  - Stimulus: all 4 requesters continuously request 2-byte messages.
  - Required: grant order 0,1,2,3,0. No message is interleaved: `grant` is constant between the first capture and the last ack.
- Contention mid-message:
  - Stimulus: req2 owns, req1 and req3 assert valid.
  - Required: no `req_ack[1]` or `req_ack[3]` until req2's last is acked; next owner is 3, then 1.
- Watchdog:
  - Stimulus: TIMEOUT=20; req1 sends its first byte, then drops valid.
  - Required: `timeout` pulse exactly 20 cycles after entering NEXT; `grant`=0; next request from req2 is served.
- Reset mid-SEND:
  - Stimulus: deassert `rst_n` asynchronously between clock edges.
  - Required: `tx_data_valid`, `grant`, and `req_ack` go to 0 immediately; after release, requester 0 wins first.
- Stray ack:
  - Stimulus: `tx_data_ack` pulsed while IDLE and while in NEXT.
  - Required: no state change, no `req_ack`.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Message-level round-robin arbiter that shares one uart_tx byte port
//   between N requesters. The winner keeps the transmitter until its byte
//   flagged 'last' is acknowledged by the UART. A watchdog drops the grant
//   if the owner stalls between bytes.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_data[8N]      byte of requester i at [8i+7:8i]
//   req_valid[N]      requester i has a byte (held until its req_ack)
//   req_last[N]       byte is the final one of the message
//   req_ack[N]        one-cycle pulse: byte of requester i captured
//   grant[N]          one-hot current owner, zero when idle
//   tx_data[8]        byte to uart_tx (held while tx_data_valid is low)
//   tx_data_valid     byte pending at uart_tx
//   tx_data_ack       one-cycle accept pulse from uart_tx
//   timeout           one-cycle pulse when the watchdog drops a grant
module uart_tx_arbiter #(
    parameter int          N       = 4,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ack,
    output logic [N-1:0]   grant,
    output logic [7:0]     tx_data,
    output logic           tx_data_valid,
    input  logic           tx_data_ack,
    output logic           timeout
);
    localparam int          PW      = $clog2(N);
    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    typedef enum logic [1:0] {IDLE, SEND, NEXT} state_t;

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n, owner, owner_n, win, cand;
    logic                win_ok, last_q, last_n;
    logic [15:0]         cnt, cnt_n;
    logic [N-1:0]        grant_n, ack_n;
    logic [7:0]          data_n;
    logic                valid_n, timeout_n;
    logic [N-1:0][7:0]   req_byte;

    assign req_byte = req_data;

    // Pointer advance with wrap for non-power-of-two N.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin pick: scan downward so the last hit is the first valid
    // requester at or after ptr.
    always_comb begin : pick
        win    = ptr;
        win_ok = 1'b0;
        cand   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr) + i) % N);
            if (req_valid[cand]) begin
                win    = cand;
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin : fsm
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        last_n    = last_q;
        cnt_n     = cnt;
        grant_n   = grant;
        ack_n     = '0;
        data_n    = tx_data;
        valid_n   = tx_data_valid;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (win_ok) begin
                    owner_n      = win;
                    data_n       = req_byte[win];
                    last_n       = req_last[win];
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                    ack_n[win]   = 1'b1;
                    valid_n      = 1'b1;
                    state_n      = SEND;
                end
            end
            SEND: begin
                // Requesters are not sampled here; the UART ack alone moves us on.
                if (tx_data_ack) begin
                    valid_n = 1'b0;
                    if (last_q) begin
                        grant_n = '0;
                        ptr_n   = inc(owner);
                        state_n = IDLE;
                    end else begin
                        cnt_n   = '0;
                        state_n = NEXT;
                    end
                end
            end
            NEXT: begin
                if (req_valid[owner]) begin
                    data_n       = req_byte[owner];
                    last_n       = req_last[owner];
                    ack_n[owner] = 1'b1;
                    valid_n      = 1'b1;
                    state_n      = SEND;
                end else if (TIMEOUT != 16'd0 && cnt == TO_LAST) begin
                    timeout_n = 1'b1;
                    grant_n   = '0;
                    ptr_n     = inc(owner);
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            last_q        <= 1'b0;
            cnt           <= '0;
            grant         <= '0;
            req_ack       <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            owner         <= owner_n;
            last_q        <= last_n;
            cnt           <= cnt_n;
            grant         <= grant_n;
            req_ack       <= ack_n;
            tx_data       <= data_n;
            tx_data_valid <= valid_n;
            timeout       <= timeout_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=4, TIMEOUT=20). All stimulus and
// observation happen on the falling clock edge through cyc(), which also
// runs the requester models (byte queues) and a UART stub that acks two
// cycles after tx_data_valid rises.
module tb_uart_tx_arbiter;
    logic        clk;
    logic        rst_n;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ack;
    logic        timeout;

    logic        stub_ack, man_ack, stub_en;
    int          st_wait, stub_acks;
    bit          st_sent;
    int          checks, errors, cyc_n, interleave;
    logic [3:0]  prev_grant;

    logic [8:0]  rq [4][$];     // {last, data}
    int          ack_log[$];
    int          grant_log[$];
    int          to_log[$];
    logic [7:0]  tx_log[$];

    assign tx_data_ack = stub_ack | man_ack;

    uart_tx_arbiter #(.N(4), .TIMEOUT(16'd20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ack(req_ack), .grant(grant),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_data_ack(tx_data_ack), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int oh2i(input logic [3:0] g);
        int r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit q_empty();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++) if (rq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic clear_logs();
        ack_log.delete(); grant_log.delete(); to_log.delete(); tx_log.delete();
        interleave = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        for (int i = 0; i < 4; i++)
            if (req_ack[i]) begin ack_log.push_back(i); tx_log.push_back(tx_data); end
        if (prev_grant == 4'b0 && grant != 4'b0) grant_log.push_back(oh2i(grant));
        if (prev_grant != 4'b0 && grant != 4'b0 && grant != prev_grant) interleave++;
        prev_grant = grant;
        if (timeout) to_log.push_back(cyc_n);
        // UART stub
        stub_ack = 1'b0;
        if (!tx_data_valid) begin
            st_wait = 0; st_sent = 1'b0;
        end else if (stub_en && !st_sent) begin
            st_wait++;
            if (st_wait == 2) begin stub_ack = 1'b1; st_sent = 1'b1; stub_acks++; end
        end
        // requester models: present queue head, advance on req_ack
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
            if (rq[i].size() != 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic run_idle(input int maxc, input string nm);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < maxc) begin
            cyc(); n++;
            done = q_empty() && grant == 4'b0 && !tx_data_valid;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL %s: no return to idle within %0d cycles", nm, maxc); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        checks += 6;
        if (grant !== 4'b0)       begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        if (req_ack !== 4'b0)     begin errors++; $display("FAIL reset_req_ack: got %b want 0000", req_ack); end
        if (tx_data !== 8'h00)    begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tx_data_valid); end
        if (timeout !== 1'b0)     begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        if (dut.ptr !== 2'd0)     begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int n = 0, bad = 0;
        logic [7:0] exp_t[3] = '{8'h41, 8'h42, 8'h43};
        clear_logs(); stub_acks = 0;
        rq[0].push_back(9'h041); rq[0].push_back(9'h042); rq[0].push_back(9'h143);
        while (stub_acks < 3 && n < 100) begin
            cyc(); n++;
            if (grant != 4'b0 && grant != 4'b0001) bad++;
        end
        checks += 2;
        if (stub_acks != 3) begin errors++; $display("FAIL single_acks: got %0d uart acks want 3", stub_acks); end
        if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant_hold: got %b want 0001", grant); end
        cyc();
        checks += 7;
        if (grant !== 4'b0) begin errors++; $display("FAIL single_release: got %b want 0000", grant); end
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", tx_data_valid); end
        if (ack_log.size() != 3) begin errors++; $display("FAIL single_req_ack_count: got %0d want 3", ack_log.size()); end
        if (bad != 0) begin errors++; $display("FAIL single_grant_owner: %0d cycles with foreign grant, want 0", bad); end
        if (dut.ptr !== 2'd1) begin errors++; $display("FAIL single_ptr: got %0d want 1", dut.ptr); end
        if (tx_data !== 8'h43) begin errors++; $display("FAIL single_hold: got %h want 43", tx_data); end
        if (tx_log.size() != 3) begin errors++; $display("FAIL single_tx_count: got %0d want 3", tx_log.size()); end
        for (int i = 0; i < 3 && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_t[i]) begin errors++; $display("FAIL single_tx_data[%0d]: got %h want %h", i, tx_log[i], exp_t[i]); end
        end
    endtask

    task automatic test_stray_ack();
        int n = 0;
        clear_logs();
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        cyc();
        checks += 3;
        if (grant !== 4'b0) begin errors++; $display("FAIL stray_idle_grant: got %b want 0000", grant); end
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL stray_idle_valid: got %b want 0", tx_data_valid); end
        if (ack_log.size() != 0) begin errors++; $display("FAIL stray_idle_req_ack: got %0d acks want 0", ack_log.size()); end
        // stalled owner in NEXT
        rq[0].push_back(9'h0A0);
        while (!(grant != 4'b0 && !tx_data_valid && ack_log.size() == 1) && n < 20) begin cyc(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL stray_reach_next: not in NEXT after %0d cycles", n); end
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        cyc();
        checks += 4;
        if (grant !== 4'b0001) begin errors++; $display("FAIL stray_next_grant: got %b want 0001", grant); end
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL stray_next_valid: got %b want 0", tx_data_valid); end
        if (ack_log.size() != 1) begin errors++; $display("FAIL stray_next_req_ack: got %0d acks want 1", ack_log.size()); end
        if (to_log.size() != 0) begin errors++; $display("FAIL stray_next_timeout: got %0d pulses want 0", to_log.size()); end
        rq[0].push_back(9'h1A1);
        run_idle(50, "stray_finish");
        checks++;
        if (tx_log.size() != 2 || tx_log[1] !== 8'hA1) begin
            errors++; $display("FAIL stray_finish_data: got %0d bytes last %h want 2 bytes last a1", tx_log.size(), tx_log[tx_log.size()-1]);
        end
    endtask

    task automatic test_fairness();
        int         exp_g[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_t[10] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h12, 8'h13};
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        clear_logs();
        rq[0].push_back(9'h010); rq[0].push_back(9'h111);
        rq[0].push_back(9'h012); rq[0].push_back(9'h113);
        rq[1].push_back(9'h020); rq[1].push_back(9'h121);
        rq[2].push_back(9'h030); rq[2].push_back(9'h131);
        rq[3].push_back(9'h040); rq[3].push_back(9'h141);
        run_idle(300, "fair_drain");
        checks += 2;
        if (grant_log.size() != 5) begin errors++; $display("FAIL fair_grant_count: got %0d want 5", grant_log.size()); end
        if (interleave != 0) begin errors++; $display("FAIL fair_interleave: got %0d owner switches inside a message want 0", interleave); end
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            checks++;
            if (grant_log[i] != exp_g[i]) begin errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, grant_log[i], exp_g[i]); end
        end
        for (int i = 0; i < 10 && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_t[i]) begin errors++; $display("FAIL fair_tx[%0d]: got %h want %h", i, tx_log[i], exp_t[i]); end
        end
    endtask

    task automatic test_contention();
        int n = 0;
        int exp_a[7] = '{2, 2, 2, 3, 3, 1, 1};
        int exp_g[3] = '{2, 3, 1};
        clear_logs();
        rq[2].push_back(9'h050); rq[2].push_back(9'h051); rq[2].push_back(9'h152);
        while (ack_log.size() == 0 && n < 20) begin cyc(); n++; end
        rq[1].push_back(9'h060); rq[1].push_back(9'h161);
        rq[3].push_back(9'h070); rq[3].push_back(9'h171);
        run_idle(300, "cont_drain");
        checks += 2;
        if (ack_log.size() != 7) begin errors++; $display("FAIL cont_ack_count: got %0d want 7", ack_log.size()); end
        if (interleave != 0) begin errors++; $display("FAIL cont_interleave: got %0d want 0", interleave); end
        for (int i = 0; i < 7 && i < ack_log.size(); i++) begin
            checks++;
            if (ack_log[i] != exp_a[i]) begin errors++; $display("FAIL cont_ack_order[%0d]: got req%0d want req%0d", i, ack_log[i], exp_a[i]); end
        end
        for (int i = 0; i < 3 && i < grant_log.size(); i++) begin
            checks++;
            if (grant_log[i] != exp_g[i]) begin errors++; $display("FAIL cont_owner[%0d]: got %0d want %0d", i, grant_log[i], exp_g[i]); end
        end
    endtask

    task automatic test_watchdog();
        int n = 0, nx, bad = 0;
        bit seen = 1'b0;
        clear_logs();
        rq[1].push_back(9'h080);
        while (!(grant != 4'b0 && !tx_data_valid && ack_log.size() == 1) && n < 20) begin cyc(); n++; end
        nx = cyc_n;
        n = 0;
        while (!seen && n < 40) begin
            cyc(); n++;
            if (timeout) seen = 1'b1;
            else if (grant !== 4'b0010) bad++;
        end
        checks += 4;
        if (!seen) begin errors++; $display("FAIL wd_pulse: no timeout within 40 cycles"); end
        if (cyc_n - nx != 20) begin errors++; $display("FAIL wd_delay: got %0d cycles want 20", cyc_n - nx); end
        if (grant !== 4'b0) begin errors++; $display("FAIL wd_release: got %b want 0000", grant); end
        if (bad != 0) begin errors++; $display("FAIL wd_grant_hold: %0d cycles without grant 0010, want 0", bad); end
        cyc();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b want 0", timeout); end
        rq[2].push_back(9'h190);
        run_idle(50, "wd_next");
        checks += 2;
        if (grant_log.size() != 2 || grant_log[1] != 2) begin errors++; $display("FAIL wd_next_owner: got %0d grants last %0d want 2 grants last 2", grant_log.size(), grant_log[grant_log.size()-1]); end
        if (tx_log.size() != 2 || tx_log[1] !== 8'h90) begin errors++; $display("FAIL wd_next_data: got %0d bytes last %h want 2 bytes last 90", tx_log.size(), tx_log[tx_log.size()-1]); end
    endtask

    task automatic test_reset_mid_send();
        int n = 0;
        clear_logs(); stub_en = 1'b0;
        rq[3].push_back(9'h1F7);
        while (ack_log.size() == 0 && n < 20) begin cyc(); n++; end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", tx_data_valid); end
        if (grant !== 4'b0) begin errors++; $display("FAIL rst_mid_grant: got %b want 0000", grant); end
        if (req_ack !== 4'b0) begin errors++; $display("FAIL rst_mid_req_ack: got %b want 0000", req_ack); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_tx_data: got %h want 00", tx_data); end
        for (int i = 0; i < 4; i++) rq[i].delete();
        req_valid = '0; req_last = '0;
        stub_ack = 1'b0; st_wait = 0; st_sent = 1'b0;
        cyc();
        rst_n = 1'b1; stub_en = 1'b1;
        clear_logs();
        rq[3].push_back(9'h1E3); rq[0].push_back(9'h1E0);
        run_idle(100, "rst_mid_drain");
        checks += 2;
        if (grant_log.size() != 2 || grant_log[0] != 0) begin errors++; $display("FAIL rst_mid_first_owner: got %0d grants first %0d want 2 grants first 0", grant_log.size(), grant_log[0]); end
        if (ack_log.size() != 2 || ack_log[1] != 3) begin errors++; $display("FAIL rst_mid_second_owner: got %0d acks second %0d want 2 acks second 3", ack_log.size(), ack_log[ack_log.size()-1]); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc_n = 0; interleave = 0;
        rst_n = 1'b0; req_data = '0; req_valid = '0; req_last = '0;
        stub_ack = 1'b0; man_ack = 1'b0; stub_en = 1'b1;
        st_wait = 0; st_sent = 1'b0; stub_acks = 0; prev_grant = '0;
        test_reset();
        test_single();
        test_stray_ack();
        test_fairness();
        test_contention();
        test_watchdog();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
